btb_victim_select: RTL and testbench

Write-side controller for the 2-way set-associative branch target buffer in the redirection pipeline. It accepts install requests from EX for mispredicted taken branches and picks the way to write: the matching way if the branch is already present, otherwise the least-recently-used way. It then issues a single write strobe plus way select to the downstream 1-of-2 write-enable decoder. Per-set LRU state is updated by IF-stage lookup hits and by writes.

---
 rtl/btb_victim_select.sv | 144 ++++++++++++++
 tb/tb_btb_victim_select.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/btb_victim_select.sv
// ---------------------------------------------------------------------------
// btb_victim_select
//
// Write-side controller for a 2-way set-associative branch target buffer.
// Accepts install requests from EX and picks the way to write: the way that
// already holds the branch, otherwise the least-recently-used way of the set.
// It then issues one write strobe plus way select to the downstream 1-of-2
// write-enable decoder. Per-set LRU bits are updated by IF-stage lookup hits
// and by the writes this block issues.
//
// Ports
//   clk_i            sole clock, rising edge
//   rst_i            asynchronous active-high reset, clears all state
//   lookup_valid_i   IF-stage BTB lookup this cycle
//   lookup_set_i     set index of the lookup
//   lookup_hit_0_i   lookup tag match in way 0
//   lookup_hit_1_i   lookup tag match in way 1
//   update_req_i     install request from EX, held until update_ack_o
//   update_set_i     set index to install into, stable while requesting
//   update_hit_0_i   branch PC already present in way 0
//   update_hit_1_i   branch PC already present in way 1
//   stall_i          pipeline stall, holds the write strobe off
//   write_enable_o   one-cycle write strobe (decoder Enable)
//   write_sel_o      way to write (decoder Sel)
//   write_set_o      set index for the write
//   update_ack_o     one-cycle pulse after the write completes
//   busy_o           high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module btb_victim_select #(
   parameter int SET_BITS = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lookup_valid_i,
   input  logic [SET_BITS-1:0] lookup_set_i,
   input  logic                lookup_hit_0_i,
   input  logic                lookup_hit_1_i,
   input  logic                update_req_i,
   input  logic [SET_BITS-1:0] update_set_i,
   input  logic                update_hit_0_i,
   input  logic                update_hit_1_i,
   input  logic                stall_i,
   output logic                write_enable_o,
   output logic                write_sel_o,
   output logic [SET_BITS-1:0] write_set_o,
   output logic                update_ack_o,
   output logic                busy_o
);

   localparam int NSETS = 1 << SET_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SET_BITS-1:0] set_q, set_d;
   logic                way_q, way_d;
   // lru_q[s] names the least-recently-used way of set s
   logic [NSETS-1:0]    lru_q, lru_d;
   logic                write_en_s;

   // The strobe is combinational so a released stall writes in that same cycle.
   assign write_en_s = (state_q == WRITE) && !stall_i;

   // Request FSM: capture set and victim in IDLE, wait out stalls, then ack.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      way_d   = way_q;
      case (state_q)
         IDLE: begin
            if (update_req_i) begin
               set_d = update_set_i;
               // A hit in both ways resolves to way 0; a miss takes the LRU way
               // as it stands now, so later lookups cannot move the victim.
               if (update_hit_0_i) begin
                  way_d = 1'b0;
               end else if (update_hit_1_i) begin
                  way_d = 1'b1;
               end else begin
                  way_d = lru_q[update_set_i];
               end
               state_d = WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (stall_i) begin
               state_d = WRITE;
            end else begin
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // LRU next state: lookup hit first, then the write so it wins on a shared set.
   always_comb begin
      lru_d = lru_q;
      if (lookup_valid_i && (lookup_hit_0_i || lookup_hit_1_i)) begin
         // Hit on way 0 (or both) makes way 1 the LRU, hit on way 1 makes way 0.
         lru_d[lookup_set_i] = lookup_hit_0_i;
      end else begin
         lru_d = lru_q;
      end
      if (write_en_s) begin
         lru_d[set_q] = ~way_q;
      end else begin
         lru_d[set_q] = lru_d[set_q];
      end
   end

   // State, captured request and LRU registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         set_q   <= {SET_BITS{1'b0}};
         way_q   <= 1'b0;
         lru_q   <= {NSETS{1'b0}};
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         way_q   <= way_d;
         lru_q   <= lru_d;
      end
   end

   assign write_enable_o = write_en_s;
   assign write_sel_o    = way_q;
   assign write_set_o    = set_q;
   assign update_ack_o   = (state_q == ACK);
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_btb_victim_select.sv
// ---------------------------------------------------------------------------
// tb_btb_victim_select
//
// Directed bench for btb_victim_select. Each table row is one clock cycle:
// inputs are applied just after the falling edge and outputs (plus the LRU
// vector) are compared 1 time unit later. Reset abort is a separate sequence.
// ---------------------------------------------------------------------------
module tb_btb_victim_select;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       lookup_valid_i;
   logic [2:0] lookup_set_i;
   logic       lookup_hit_0_i;
   logic       lookup_hit_1_i;
   logic       update_req_i;
   logic [2:0] update_set_i;
   logic       update_hit_0_i;
   logic       update_hit_1_i;
   logic       stall_i;
   logic       write_enable_o;
   logic       write_sel_o;
   logic [2:0] write_set_o;
   logic       update_ack_o;
   logic       busy_o;

   btb_victim_select #(.SET_BITS(3)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .lookup_valid_i (lookup_valid_i),
      .lookup_set_i   (lookup_set_i),
      .lookup_hit_0_i (lookup_hit_0_i),
      .lookup_hit_1_i (lookup_hit_1_i),
      .update_req_i   (update_req_i),
      .update_set_i   (update_set_i),
      .update_hit_0_i (update_hit_0_i),
      .update_hit_1_i (update_hit_1_i),
      .stall_i        (stall_i),
      .write_enable_o (write_enable_o),
      .write_sel_o    (write_sel_o),
      .write_set_o    (write_set_o),
      .update_ack_o   (update_ack_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int req, uset, uh0, uh1;
      int lv, lset, lh0, lh1;
      int stall;
      int we, sel, wset, ack, busy, lru;
   } vec_t;

   vec_t vecs[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input int row, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s (row %0d): got %0d, expected %0d", name, row, act, exp);
   endtask

   task automatic add(input int req, uset, uh0, uh1, lv, lset, lh0, lh1, stall,
                      input int we, sel, wset, ack, busy, lru);
      vec_t v;
      v = '{req, uset, uh0, uh1, lv, lset, lh0, lh1, stall, we, sel, wset, ack, busy, lru};
      vecs.push_back(v);
   endtask

   task automatic check_all(input int row, input int we, sel, wset, ack, busy, lru);
      chk("write_enable", row, int'(write_enable_o), we);
      chk("write_sel",    row, int'(write_sel_o),    sel);
      chk("write_set",    row, int'(write_set_o),    wset);
      chk("update_ack",   row, int'(update_ack_o),   ack);
      chk("busy",         row, int'(busy_o),         busy);
      chk("lru",          row, int'(dut.lru_q),      lru);
   endtask

   initial begin
      //   req set h0 h1  lv ls l0 l1 stl   we sel set ack busy lru
      // miss install into set 5: victim way 0, lru[5] -> 1
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 8'h00);
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   1, 0, 5, 0, 1, 8'h00);
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   0, 0, 5, 1, 1, 8'h20);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 5, 0, 0, 8'h20);
      // second miss into set 5 takes way 1, lru[5] -> 0
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   0, 0, 5, 0, 0, 8'h20);
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   1, 1, 5, 0, 1, 8'h20);
      add(1, 5, 0, 0,  0, 0, 0, 0, 0,   0, 1, 5, 1, 1, 8'h00);
      // request still high after ACK is a new one; hit in way 1 overrides LRU
      add(1, 5, 0, 1,  0, 0, 0, 0, 0,   0, 1, 5, 0, 0, 8'h00);
      add(1, 5, 0, 1,  0, 0, 0, 0, 0,   1, 1, 5, 0, 1, 8'h00);
      add(1, 5, 0, 1,  0, 0, 0, 0, 0,   0, 1, 5, 1, 1, 8'h00);
      // lookup hit way 0 of set 2, then a miss install there uses way 1
      add(0, 0, 0, 0,  1, 2, 1, 0, 0,   0, 1, 5, 0, 0, 8'h00);
      add(1, 2, 0, 0,  0, 0, 0, 0, 0,   0, 1, 5, 0, 0, 8'h04);
      add(1, 2, 0, 0,  0, 0, 0, 0, 0,   1, 1, 2, 0, 1, 8'h04);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 2, 1, 1, 8'h00);
      // three stall cycles in WRITE: no strobe, sel/set steady
      add(1, 6, 0, 0,  0, 0, 0, 0, 1,   0, 1, 2, 0, 0, 8'h00);
      add(1, 6, 0, 0,  0, 0, 0, 0, 1,   0, 0, 6, 0, 1, 8'h00);
      add(1, 6, 0, 0,  0, 0, 0, 0, 1,   0, 0, 6, 0, 1, 8'h00);
      add(1, 6, 0, 0,  0, 0, 0, 0, 1,   0, 0, 6, 0, 1, 8'h00);
      add(1, 6, 0, 0,  0, 0, 0, 0, 0,   1, 0, 6, 0, 1, 8'h00);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 6, 1, 1, 8'h40);
      // write set 3 way 0 with same-cycle lookup hit way 1 of set 3: write wins
      add(1, 3, 1, 0,  0, 0, 0, 0, 0,   0, 0, 6, 0, 0, 8'h40);
      add(1, 3, 1, 0,  1, 3, 0, 1, 0,   1, 0, 3, 0, 1, 8'h40);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 3, 1, 1, 8'h48);
      // write set 3 way 1 with lookup hit way 1 of set 4: both apply
      add(1, 3, 0, 1,  1, 4, 1, 0, 0,   0, 0, 3, 0, 0, 8'h48);
      add(1, 3, 0, 1,  1, 4, 0, 1, 0,   1, 1, 3, 0, 1, 8'h58);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 1, 3, 1, 1, 8'h40);
      // both update hits -> way 0; both lookup hits count as way 0
      add(1, 0, 1, 1,  1, 1, 1, 1, 0,   0, 1, 3, 0, 0, 8'h40);
      add(1, 0, 1, 1,  0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 8'h42);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 8'h43);
      // lookup with no hit leaves LRU alone
      add(0, 0, 0, 0,  1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 8'h43);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 8'h43);

      rst_i = 1'b1;
      lookup_valid_i = 1'b0; lookup_set_i = 3'd0;
      lookup_hit_0_i = 1'b0; lookup_hit_1_i = 1'b0;
      update_req_i = 1'b0; update_set_i = 3'd0;
      update_hit_0_i = 1'b0; update_hit_1_i = 1'b0;
      stall_i = 1'b0;

      @(negedge clk_i);
      #1;
      check_all(-1, 0, 0, 0, 0, 0, 8'h00);
      rst_i = 1'b0;
      @(negedge clk_i);

      foreach (vecs[i]) begin
         update_req_i   = vecs[i].req[0];
         update_set_i   = 3'(vecs[i].uset);
         update_hit_0_i = vecs[i].uh0[0];
         update_hit_1_i = vecs[i].uh1[0];
         lookup_valid_i = vecs[i].lv[0];
         lookup_set_i   = 3'(vecs[i].lset);
         lookup_hit_0_i = vecs[i].lh0[0];
         lookup_hit_1_i = vecs[i].lh1[0];
         stall_i        = vecs[i].stall[0];
         #1;
         check_all(i, vecs[i].we, vecs[i].sel, vecs[i].wset,
                   vecs[i].ack, vecs[i].busy, vecs[i].lru);
         @(negedge clk_i);
      end

      // Reset during WRITE aborts the request; held request restarts after release.
      update_req_i = 1'b1; update_set_i = 3'd7;
      update_hit_0_i = 1'b0; update_hit_1_i = 1'b0;
      lookup_valid_i = 1'b0; stall_i = 1'b0;
      @(negedge clk_i);
      #1;
      check_all(100, 1, 0, 7, 0, 1, 8'h43);
      #1 rst_i = 1'b1;
      #1;
      check_all(101, 0, 0, 0, 0, 0, 8'h00);
      @(negedge clk_i);
      #1;
      check_all(102, 0, 0, 0, 0, 0, 8'h00);
      rst_i = 1'b0;
      @(negedge clk_i);
      #1;
      check_all(103, 1, 0, 7, 0, 1, 8'h00);
      @(negedge clk_i);
      #1;
      check_all(104, 0, 0, 7, 1, 1, 8'h80);
      update_req_i = 1'b0;
      @(negedge clk_i);
      #1;
      check_all(105, 0, 0, 7, 0, 0, 8'h80);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
